// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_pkg;

  // Receiver alignment state.
  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Word-select encoding: 0 = left channel, 1 = right channel.
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Default sample width.
  localparam int AUDIO_DW_DEF = 8;

  // Bit counter width: must hold values 0 .. dw+1 (saturation point).
  function automatic int cnt_width(input int dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// i2s_rx_if: parallel sample bus out of the I2S receiver.
// Latency: n/a (wires only); master = receiver, slave = sample consumer.
// Backpressure: none; strobes are one-cycle pulses the consumer must accept.
interface i2s_rx_if
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW = AUDIO_DW_DEF
);
  logic [AUDIO_DW-1:0] l_data_o;       // last completed left word
  logic [AUDIO_DW-1:0] r_data_o;       // last completed right word
  logic                l_valid_o;      // l_data_o updated this cycle
  logic                r_valid_o;      // r_data_o updated this cycle
  logic                frame_valid_o;  // right publish closing a full L/R frame

  modport master (
    output l_data_o, r_data_o, l_valid_o, r_valid_o, frame_valid_o
  );

  modport slave (
    input l_data_o, r_data_o, l_valid_o, r_valid_o, frame_valid_o
  );
endinterface

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: synchronizer chains for SCK/WS/SD plus SCK rise-event detection.
// Latency: SYNC_STAGES clk_i cycles for ws/sd; rise flagged when sck_s is 1 and its delayed copy is 0.
// Backpressure: none.
// Ports: clk_i/rst_i; sck_i, ws_i, sd_i async pins in; sck_rise_o, ws_s_o, sd_s_o out.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic sck_rise_o,
  output logic ws_s_o,
  output logic sd_s_o
);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] ws_sr;
  logic [SYNC_STAGES-1:0] sd_sr;
  logic                   sck_d;

  // All three pins go through equal-depth chains so WS/SD stay aligned
  // with the SCK rise they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sr <= '0;
      ws_sr  <= '0;
      sd_sr  <= '0;
      sck_d  <= 1'b0;
    end else begin
      sck_sr <= {sck_sr[SYNC_STAGES-2:0], sck_i};
      ws_sr  <= {ws_sr[SYNC_STAGES-2:0], ws_i};
      sd_sr  <= {sd_sr[SYNC_STAGES-2:0], sd_i};
      sck_d  <= sck_sr[SYNC_STAGES-1];
    end
  end

  assign sck_rise_o = sck_sr[SYNC_STAGES-1] & ~sck_d;
  assign ws_s_o     = ws_sr[SYNC_STAGES-1];
  assign sd_s_o     = sd_sr[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver, oversampled on clk_i; MSB-first L/R words published with 1-cycle strobes.
// Latency: data/valid registered at the clk_i edge that processes the SCK rise (3rd edge after sck_i high at defaults).
// Backpressure: none; each published word is a single-cycle pulse on the smp bus.
// Ports: clk_i, rst_i (async, active-high), enable_i, sck_i/ws_i/sd_i pins, smp (i2s_rx_if.master).
// Optional: define I2S_RX_ERR_EN to add err_cnt_o / err_clr_i (saturating framing-error counter).
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW    = AUDIO_DW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       sck_i,
  input  logic       ws_i,
  input  logic       sd_i,
`ifdef I2S_RX_ERR_EN
  input  logic       err_clr_i,
  output logic [7:0] err_cnt_o,
`endif
  i2s_rx_if.master   smp
);

  localparam int CW = cnt_width(AUDIO_DW);
  localparam logic [CW-1:0] CNT_MAX = CW'(AUDIO_DW + 1);
  localparam logic [CW-1:0] CNT_DW  = CW'(AUDIO_DW);

  logic sck_rise, ws_s, sd_s;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sck_i     (sck_i),
    .ws_i      (ws_i),
    .sd_i      (sd_i),
    .sck_rise_o(sck_rise),
    .ws_s_o    (ws_s),
    .sd_s_o    (sd_s)
  );

  state_e              state_q, state_d;
  logic                ws_prev_q, ws_prev_d;
  logic                ch_q, ch_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [AUDIO_DW-1:0] shift_q, shift_d, shift_upd;
  logic                left_seen_q, left_seen_d;
  logic [AUDIO_DW-1:0] l_data_q, l_data_d, r_data_q, r_data_d;
  logic                l_vld_q, l_vld_d, r_vld_q, r_vld_d, frm_vld_q, frm_vld_d;
`ifdef I2S_RX_ERR_EN
  logic                err_inc;
  logic [7:0]          err_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ws_prev_d   = ws_prev_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    left_seen_d = left_seen_q;
    l_data_d    = l_data_q;
    r_data_d    = r_data_q;
    l_vld_d     = 1'b0;
    r_vld_d     = 1'b0;
    frm_vld_d   = 1'b0;
`ifdef I2S_RX_ERR_EN
    err_inc     = 1'b0;
`endif

    // Shift value including the bit at this rise; bits past AUDIO_DW match
    // no index and are dropped, and unwritten LSBs stay 0 for short words.
    shift_upd = shift_q;
    for (int i = 0; i < AUDIO_DW; i++) begin
      if (cnt_q == CW'(AUDIO_DW - 1 - i)) shift_upd[i] = sd_s;
    end
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    if (!enable_i) begin
      state_d     = HUNT;
      cnt_d       = '0;
      shift_d     = '0;
      left_seen_d = 1'b0;
    end else if (sck_rise) begin
      ws_prev_d = ws_s;
      unique case (state_q)
        HUNT: state_d = ALIGN;
        ALIGN: begin
          // First WS edge seen: the next rise carries a fresh MSB.
          if (ws_s != ws_prev_q) begin
            ch_d    = ws_s;
            cnt_d   = '0;
            shift_d = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (ws_s != ws_prev_q) begin
            // WS change: this rise carries the LSB of the word for ch_q.
            if (ch_q == CH_LEFT) begin
              l_data_d    = shift_upd;
              l_vld_d     = 1'b1;
              left_seen_d = 1'b1;
            end else begin
              r_data_d    = shift_upd;
              r_vld_d     = 1'b1;
              frm_vld_d   = left_seen_q;
              left_seen_d = 1'b0;
            end
`ifdef I2S_RX_ERR_EN
            err_inc = (cnt_inc != CNT_DW);
`endif
            shift_d = '0;
            cnt_d   = '0;
            ch_d    = ws_s;
          end else begin
            shift_d = shift_upd;
            cnt_d   = cnt_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ws_prev_q   <= 1'b0;
      ch_q        <= CH_LEFT;
      cnt_q       <= '0;
      shift_q     <= '0;
      left_seen_q <= 1'b0;
      l_data_q    <= '0;
      r_data_q    <= '0;
      l_vld_q     <= 1'b0;
      r_vld_q     <= 1'b0;
      frm_vld_q   <= 1'b0;
    end else begin
      ws_prev_q   <= ws_prev_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_seen_q <= left_seen_d;
      l_data_q    <= l_data_d;
      r_data_q    <= r_data_d;
      l_vld_q     <= l_vld_d;
      r_vld_q     <= r_vld_d;
      frm_vld_q   <= frm_vld_d;
    end
  end

`ifdef I2S_RX_ERR_EN
  // Clear wins over a same-cycle increment; count sticks at 255.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          err_q <= 8'd0;
    else if (err_clr_i)                 err_q <= 8'd0;
    else if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_cnt_o = err_q;
`endif

  assign smp.l_data_o      = l_data_q;
  assign smp.r_data_o      = r_data_q;
  assign smp.l_valid_o     = l_vld_q;
  assign smp.r_valid_o     = r_vld_q;
  assign smp.frame_valid_o = frm_vld_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: scoreboard bench for i2s_rx at AUDIO_DW=8, sck = clk_i/8.
// Expected words are queued as bits are driven and checked when the DUT pulses.
// Optional I2S_RX_ERR_EN checks follow the same macro as the design.
module tb_i2s_rx;
  import i2s_pkg::*;

  typedef struct packed {
    logic       ch;
    logic [7:0] data;
    logic       frame;
  } exp_t;

  logic clk_i, rst_i, enable_i, sck_i, ws_i, sd_i;
`ifdef I2S_RX_ERR_EN
  logic       err_clr_i;
  logic [7:0] err_cnt_o;
`endif

  i2s_rx_if #(.AUDIO_DW(8)) smp ();

  i2s_rx #(.AUDIO_DW(8), .SYNC_STAGES(2)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .sck_i    (sck_i),
    .ws_i     (ws_i),
    .sd_i     (sd_i),
`ifdef I2S_RX_ERR_EN
    .err_clr_i(err_clr_i),
    .err_cnt_o(err_cnt_o),
`endif
    .smp      (smp)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_exp = 0;
  exp_t exp_q[$];
  logic [7:0] last_l = 8'h00;
  logic [7:0] last_r = 8'h00;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t       mon_e;
  logic       l_vld_prev = 1'b0, r_vld_prev = 1'b0;
  logic [7:0] l_dat_prev = 8'h00, r_dat_prev = 8'h00;

  always @(negedge clk_i) begin
    if (rst_i) begin
      l_vld_prev = 1'b0;
      r_vld_prev = 1'b0;
      l_dat_prev = smp.l_data_o;
      r_dat_prev = smp.r_data_o;
    end else begin
      if (smp.l_valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_l_pulse: got data=%h, required no pulse", smp.l_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.ch !== CH_LEFT || smp.l_data_o !== mon_e.data) begin
            n_bad++;
            $display("FAIL left_word: got ch0 data=%h, required ch%0d data=%h",
                     smp.l_data_o, mon_e.ch, mon_e.data);
          end
        end
        n_cmp++;
        if (l_vld_prev) begin
          n_bad++;
          $display("FAIL l_pulse_width: got >1 cycle, required 1");
        end
      end
      if (smp.r_valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_r_pulse: got data=%h, required no pulse", smp.r_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.ch !== CH_RIGHT || smp.r_data_o !== mon_e.data ||
              smp.frame_valid_o !== mon_e.frame) begin
            n_bad++;
            $display("FAIL right_word: got ch1 data=%h frame=%b, required ch%0d data=%h frame=%b",
                     smp.r_data_o, smp.frame_valid_o, mon_e.ch, mon_e.data, mon_e.frame);
          end
        end
        n_cmp++;
        if (r_vld_prev) begin
          n_bad++;
          $display("FAIL r_pulse_width: got >1 cycle, required 1");
        end
      end
      if (smp.frame_valid_o && !smp.r_valid_o) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_alone: got frame_valid=1 with r_valid=0, required coincident");
      end
      n_cmp++;
      if ((smp.l_data_o !== l_dat_prev && !smp.l_valid_o) ||
          (smp.r_data_o !== r_dat_prev && !smp.r_valid_o)) begin
        n_bad++;
        $display("FAIL data_hold: got l=%h r=%h, required l=%h r=%h",
                 smp.l_data_o, smp.r_data_o, l_dat_prev, r_dat_prev);
      end
      l_vld_prev = smp.l_valid_o;
      r_vld_prev = smp.r_valid_o;
      l_dat_prev = smp.l_data_o;
      r_dat_prev = smp.r_data_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // One SCK period: low 4 clk_i with WS/SD set, then high 4 clk_i.
  task automatic send_bit(input logic ws, input logic sd);
    sck_i = 1'b0;
    ws_i  = ws;
    sd_i  = sd;
    wait_clks(4);
    sck_i = 1'b1;
    wait_clks(4);
  endtask

  // Word for channel ch, n bits MSB-first; WS flips one bit before the
  // next word's MSB. If pub, the expected publish is queued first.
  task automatic send_word(input logic ch, input logic [15:0] val, input int n,
                           input bit pub, input bit frm);
    exp_t        e;
    logic [15:0] t;
    if (pub) begin
      t = (n >= 8) ? (val >> (n - 8)) : (val << (8 - n));
      e.ch    = ch;
      e.data  = t[7:0];
      e.frame = frm;
      exp_q.push_back(e);
      if (ch == CH_LEFT) last_l = t[7:0];
      else               last_r = t[7:0];
      if (n != 8) err_exp++;
    end
    for (int i = 0; i < n; i++) begin
      send_bit((i == n - 1) ? ~ch : ch, val[n-1-i]);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk_i);
    wait_clks(4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1; enable_i = 1'b0; sck_i = 1'b0; ws_i = 1'b0; sd_i = 1'b0;
`ifdef I2S_RX_ERR_EN
    err_clr_i = 1'b0;
`endif
    wait_clks(3);
    n_cmp++;
    if (smp.l_data_o !== 8'h00 || smp.r_data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got l=%h r=%h, required 00 00", smp.l_data_o, smp.r_data_o);
    end
    n_cmp++;
    if ({smp.l_valid_o, smp.r_valid_o, smp.frame_valid_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_valids: got %b%b%b, required 000",
               smp.l_valid_o, smp.r_valid_o, smp.frame_valid_o);
    end
`ifdef I2S_RX_ERR_EN
    n_cmp++;
    if (err_cnt_o !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt_o);
    end
`endif
    rst_i = 1'b0;
    enable_i = 1'b1;
    wait_clks(2);
  endtask

  task automatic test_nominal();
    send_word(CH_RIGHT, 16'h00, 8, 0, 0);   // HUNT/ALIGN, no publish
    send_word(CH_LEFT,  16'hA5, 8, 1, 0);
    send_word(CH_RIGHT, 16'h3C, 8, 1, 1);
    send_word(CH_LEFT,  16'h5A, 8, 1, 0);
    send_word(CH_RIGHT, 16'hC3, 8, 1, 1);
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL nominal_drain: got %0d pending, required 0", exp_q.size());
    end
    n_cmp++;
    if (smp.l_data_o !== 8'h5A || smp.r_data_o !== 8'hC3) begin
      n_bad++;
      $display("FAIL nominal_data: got l=%h r=%h, required 5a c3", smp.l_data_o, smp.r_data_o);
    end
  endtask

  task automatic test_short_long();
    send_word(CH_LEFT,  16'h96,    8,  1, 0);
    send_word(CH_RIGHT, 16'h002D,  6,  1, 1);  // 101101 -> B4
    send_word(CH_LEFT,  16'h02FF,  10, 1, 0);  // 1011111111 -> BF
    send_word(CH_RIGHT, 16'h3C,    8,  1, 1);
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL short_long_drain: got %0d pending, required 0", exp_q.size());
    end
`ifdef I2S_RX_ERR_EN
    n_cmp++;
    if (err_cnt_o !== 8'(err_exp)) begin
      n_bad++;
      $display("FAIL err_cnt_count: got %0d, required %0d", err_cnt_o, err_exp);
    end
    // Clear held across a short word: the increment must be suppressed.
    err_clr_i = 1'b1;
    send_word(CH_LEFT, 16'h000F, 4, 1, 0);
    err_clr_i = 1'b0;
    err_exp = 0;
    wait_clks(2);
    n_cmp++;
    if (err_cnt_o !== 8'd0) begin
      n_bad++;
      $display("FAIL err_cnt_clear: got %0d, required 0", err_cnt_o);
    end
    send_word(CH_RIGHT, 16'h81, 8, 1, 1);
    wait_drain();
`endif
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 4; i++) send_bit(CH_LEFT, i[0]);
    enable_i = 1'b0;
    send_word(CH_RIGHT, 16'hFF, 8, 0, 0);
    for (int i = 0; i < 3; i++) send_bit(CH_LEFT, 1'b1);
    n_cmp++;
    if (smp.l_data_o !== last_l || smp.r_data_o !== last_r) begin
      n_bad++;
      $display("FAIL enable_hold: got l=%h r=%h, required l=%h r=%h",
               smp.l_data_o, smp.r_data_o, last_l, last_r);
    end
    enable_i = 1'b1;
    send_word(CH_LEFT,  16'h11, 8, 0, 0);   // realign on its closing WS edge
    send_word(CH_RIGHT, 16'h77, 8, 1, 0);   // no left in this frame
    send_word(CH_LEFT,  16'h12, 8, 1, 0);
    send_word(CH_RIGHT, 16'h34, 8, 1, 1);
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL enable_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_loopback();
    for (int f = 0; f < 16; f++) begin
      send_word(CH_LEFT,  16'h01, 8, 1, 0);
      send_word(CH_RIGHT, 16'h80, 8, 1, 1);
    end
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL loopback_drain: got %0d pending, required 0", exp_q.size());
    end
`ifdef I2S_RX_ERR_EN
    n_cmp++;
    if (err_cnt_o !== 8'd0) begin
      n_bad++;
      $display("FAIL loopback_err_cnt: got %0d, required 0", err_cnt_o);
    end
`endif
  endtask

  task automatic test_startup_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(CH_LEFT, 1'b1);
    sck_i = 1'b0;
    wait_clks(2);
    n_cmp++;
    if (smp.l_data_o !== 8'h00 || smp.r_data_o !== 8'h00) begin
      n_bad++;
      $display("FAIL midreset_data: got l=%h r=%h, required 00 00", smp.l_data_o, smp.r_data_o);
    end
    rst_i = 1'b0;
    err_exp = 0;
    // Remainder of the interrupted left word: HUNT, then ALIGN on its WS edge.
    for (int i = 0; i < 4; i++) send_bit(CH_LEFT, 1'b0);
    send_bit(CH_RIGHT, 1'b1);
    send_word(CH_RIGHT, 16'h5C, 8, 1, 0);
    send_word(CH_LEFT,  16'h3A, 8, 1, 0);
    send_word(CH_RIGHT, 16'hC5, 8, 1, 1);
    wait_drain();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL startup_drain: got %0d pending, required 0", exp_q.size());
    end
`ifdef I2S_RX_ERR_EN
    n_cmp++;
    if (err_cnt_o !== 8'd0) begin
      n_bad++;
      $display("FAIL startup_err_cnt: got %0d, required 0", err_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_long();
    test_enable_drop();
    test_loopback();
    test_startup_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
